// File: rtl/exp7_unidade_controle_if.sv
// exp7_unidade_controle_if: control/condition bundle between the memory-game control unit and its datapath
interface exp7_unidade_controle_if;
  logic iniciar;
  logic jogada_feita, jogada_correta, enderecoIgualRodada;
  logic fimC, fimCR, meioCR, fimTM, meioTM, fimTempo;
  logic nivel_jogadas_reg, nivel_tempo_reg;
  logic zeraR, registraR, zeraC, contaC, registraN, zeraCR, contaCR;
  logic zeraTM, contaTM, zeraTempo, contaTempo;
  logic ativa_leds_mem, ativa_leds_jog, toca, gravaM;
  logic pronto, ganhou, perdeu, timeout;
  logic [4:0] db_estado;
  modport master (
    input iniciar, jogada_feita, jogada_correta, enderecoIgualRodada,
          fimC, fimCR, meioCR, fimTM, meioTM, fimTempo,
          nivel_jogadas_reg, nivel_tempo_reg,
    output zeraR, registraR, zeraC, contaC, registraN, zeraCR, contaCR,
           zeraTM, contaTM, zeraTempo, contaTempo,
           ativa_leds_mem, ativa_leds_jog, toca, gravaM,
           pronto, ganhou, perdeu, timeout, db_estado
  );
  modport slave (
    output iniciar, jogada_feita, jogada_correta, enderecoIgualRodada,
           fimC, fimCR, meioCR, fimTM, meioTM, fimTempo,
           nivel_jogadas_reg, nivel_tempo_reg,
    input zeraR, registraR, zeraC, contaC, registraN, zeraCR, contaCR,
          zeraTM, contaTM, zeraTempo, contaTempo,
          ativa_leds_mem, ativa_leds_jog, toca, gravaM,
          pronto, ganhou, perdeu, timeout, db_estado
  );
endinterface

// File: rtl/exp7_unidade_controle.sv
// exp7_unidade_controle: Moore control unit sequencing the memory-game datapath; define TIMEOUT_EN to enable the per-move timeout
module exp7_unidade_controle (
  input logic clock,
  input logic reset,
  exp7_unidade_controle_if.master bus
);
  typedef enum logic [4:0] {
    inicial       = 5'h00,
    preparacao    = 5'h01,
    registraNivel = 5'h02,
    iniciaRodada  = 5'h03,
    mostra        = 5'h04,
    apaga         = 5'h05,
    proximoMostra = 5'h06,
    fimMostra     = 5'h07,
    esperaJogada  = 5'h08,
    registra      = 5'h09,
    comparacao    = 5'h0A,
    proximaJogada = 5'h0B,
    adiciona      = 5'h0C,
    esperaEscrita = 5'h0D,
    registraNova  = 5'h0E,
    grava         = 5'h0F,
    fimAcerto     = 5'h10,
    fimErro       = 5'h11,
    fimTimeout    = 5'h12
  } estado_t;
  estado_t estado, proxEstado;
  logic ultima, fimTempoEf, esperando, unusedCond;
  assign ultima = bus.nivel_jogadas_reg ? bus.fimCR : bus.meioCR;
  assign esperando = estado == esperaJogada || estado == esperaEscrita;
  assign unusedCond = bus.fimC;
`ifdef TIMEOUT_EN
  assign fimTempoEf = bus.fimTempo;
  assign bus.contaTempo = esperando & bus.nivel_tempo_reg;
`else
  logic unusedTempo;
  assign unusedTempo = bus.fimTempo ^ bus.nivel_tempo_reg ^ esperando;
  assign fimTempoEf = 1'b0;
  assign bus.contaTempo = 1'b0;
`endif
  // state register with synchronous reset
  always_ff @(posedge clock)
    estado <= reset ? inicial : proxEstado;
  // next-state decode; unused codes fall back to inicial
  always_comb begin
    proxEstado = inicial;
    case (estado)
      inicial:       proxEstado = bus.iniciar ? preparacao : inicial;
      preparacao:    proxEstado = registraNivel;
      registraNivel: proxEstado = iniciaRodada;
      iniciaRodada:  proxEstado = mostra;
      mostra:        proxEstado = bus.meioTM ? apaga : mostra;
      apaga:         proxEstado = !bus.fimTM ? apaga : bus.enderecoIgualRodada ? fimMostra : proximoMostra;
      proximoMostra: proxEstado = mostra;
      fimMostra:     proxEstado = esperaJogada;
      esperaJogada:  proxEstado = bus.jogada_feita ? registra : fimTempoEf ? fimTimeout : esperaJogada;
      registra:      proxEstado = comparacao;
      comparacao:    proxEstado = !bus.jogada_correta ? fimErro : !bus.enderecoIgualRodada ? proximaJogada : ultima ? fimAcerto : adiciona;
      proximaJogada: proxEstado = esperaJogada;
      adiciona:      proxEstado = esperaEscrita;
      esperaEscrita: proxEstado = bus.jogada_feita ? registraNova : fimTempoEf ? fimTimeout : esperaEscrita;
      registraNova:  proxEstado = grava;
      grava:         proxEstado = iniciaRodada;
      fimAcerto:     proxEstado = bus.iniciar ? preparacao : fimAcerto;
      fimErro:       proxEstado = bus.iniciar ? preparacao : fimErro;
      fimTimeout:    proxEstado = bus.iniciar ? preparacao : fimTimeout;
      default:       proxEstado = inicial;
    endcase
  end
  assign bus.zeraR          = estado == preparacao;
  assign bus.registraR      = estado == registra || estado == registraNova;
  assign bus.zeraC          = estado == preparacao || estado == iniciaRodada || estado == fimMostra;
  assign bus.contaC         = estado == proximoMostra || estado == proximaJogada || estado == adiciona;
  assign bus.registraN      = estado == registraNivel;
  assign bus.zeraCR         = estado == preparacao;
  assign bus.contaCR        = estado == grava;
  assign bus.zeraTM         = estado == preparacao || estado == iniciaRodada || estado == proximoMostra;
  assign bus.contaTM        = estado == mostra || estado == apaga;
  assign bus.zeraTempo      = estado == preparacao || estado == fimMostra || estado == proximaJogada || estado == adiciona;
  assign bus.ativa_leds_mem = estado == mostra;
  assign bus.ativa_leds_jog = estado == registra || estado == comparacao || estado == registraNova;
  assign bus.toca           = estado == mostra || estado == registra || estado == comparacao || estado == registraNova;
  assign bus.gravaM         = estado == grava;
  assign bus.pronto         = estado == fimAcerto || estado == fimErro || estado == fimTimeout;
  assign bus.ganhou         = estado == fimAcerto;
  assign bus.perdeu         = estado == fimErro;
  assign bus.timeout        = estado == fimTimeout;
  assign bus.db_estado      = estado;
endmodule

// File: tb/tb_exp7_unidade_controle.sv
// tb_exp7_unidade_controle: directed self-checking bench for the memory-game control unit
module tb_exp7_unidade_controle;
  logic clock = 0, reset = 1;
  int errors = 0, checks = 0;
  exp7_unidade_controle_if bus ();
  exp7_unidade_controle dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  localparam logic [18:0] ZR = 19'h40000, RR = 19'h20000, ZC = 19'h10000, CC = 19'h08000,
    RN = 19'h04000, ZCR = 19'h02000, CCR = 19'h01000, ZTM = 19'h00800, CTM = 19'h00400,
    ZT = 19'h00200, CT = 19'h00100, ALM = 19'h00080, ALJ = 19'h00040, TOC = 19'h00020,
    GM = 19'h00010, PR = 19'h00008, GA = 19'h00004, PE = 19'h00002, TO = 19'h00001;
  logic [18:0] outs;
  assign outs = {bus.zeraR, bus.registraR, bus.zeraC, bus.contaC, bus.registraN, bus.zeraCR,
    bus.contaCR, bus.zeraTM, bus.contaTM, bus.zeraTempo, bus.contaTempo, bus.ativa_leds_mem,
    bus.ativa_leds_jog, bus.toca, bus.gravaM, bus.pronto, bus.ganhou, bus.perdeu, bus.timeout};
  task automatic step(input string tag, input logic [4:0] es, input logic [18:0] eo);
    @(posedge clock);
    #1;
    checks += 2;
    assert (bus.db_estado === es) else begin
      errors++;
      $error("FAIL %s db_estado observed=%0h expected=%0h", tag, bus.db_estado, es);
    end
    assert (outs === eo) else begin
      errors++;
      $error("FAIL %s outputs observed=%05h expected=%05h", tag, outs, eo);
    end
  endtask
  initial begin
    {bus.iniciar, bus.jogada_feita, bus.jogada_correta, bus.enderecoIgualRodada, bus.fimC,
     bus.fimCR, bus.meioCR, bus.fimTM, bus.meioTM, bus.fimTempo, bus.nivel_jogadas_reg,
     bus.nivel_tempo_reg} = '0;
    step("rst0", 5'h00, 0);
    step("rst1", 5'h00, 0);
    reset = 0; bus.iniciar = 1;
    step("pre_a", 5'h01, ZR | ZC | ZCR | ZTM | ZT);
    step("niv_a", 5'h02, RN);
    step("ini_a", 5'h03, ZC | ZTM);
    reset = 1;
    step("rst2", 5'h00, 0);
    step("rst3", 5'h00, 0);
    reset = 0;
    step("pre", 5'h01, ZR | ZC | ZCR | ZTM | ZT);
    step("niv", 5'h02, RN);
    step("ini", 5'h03, ZC | ZTM);
    step("mostra", 5'h04, ALM | TOC | CTM);
    bus.iniciar = 0;
    for (int i = 0; i < 4; i++) step("mostra_hold", 5'h04, ALM | TOC | CTM);
    bus.meioTM = 1;
    step("apaga", 5'h05, CTM);
    bus.meioTM = 0; bus.enderecoIgualRodada = 1;
    for (int i = 0; i < 4; i++) step("apaga_hold", 5'h05, CTM);
    bus.fimTM = 1;
    step("fim_mostra", 5'h07, ZC | ZT);
    bus.fimTM = 0;
    step("espera", 5'h08, 0);
`ifndef TIMEOUT_EN
    bus.fimTempo = 1;
    step("espera_no_to", 5'h08, 0);
`endif
    bus.fimTempo = 1; bus.jogada_feita = 1;
    step("prio_jogada", 5'h09, RR | ALJ | TOC);
    bus.fimTempo = 0; bus.jogada_feita = 0; bus.jogada_correta = 1;
    step("comp", 5'h0A, ALJ | TOC);
    step("adiciona", 5'h0C, CC | ZT);
    step("esp_escr", 5'h0D, 0);
    step("esp_escr_hold", 5'h0D, 0);
    bus.jogada_feita = 1;
    step("reg_nova", 5'h0E, RR | ALJ | TOC);
    bus.jogada_feita = 0;
    step("grava", 5'h0F, GM | CCR);
    step("ini_r1", 5'h03, ZC | ZTM);
    bus.meioTM = 1;
    step("mostra_r1", 5'h04, ALM | TOC | CTM);
    step("apaga_r1", 5'h05, CTM);
    bus.meioTM = 0; bus.fimTM = 1; bus.enderecoIgualRodada = 0;
    step("prox_mostra", 5'h06, CC | ZTM);
    step("mostra_r1b", 5'h04, ALM | TOC | CTM);
    bus.meioTM = 1;
    step("apaga_r1b", 5'h05, CTM);
    bus.enderecoIgualRodada = 1;
    step("fim_mostra_r1", 5'h07, ZC | ZT);
    bus.meioTM = 0; bus.fimTM = 0;
    step("espera_r1", 5'h08, 0);
    bus.jogada_feita = 1;
    step("reg_r1", 5'h09, RR | ALJ | TOC);
    bus.jogada_feita = 0; bus.jogada_correta = 0;
    step("comp_r1", 5'h0A, ALJ | TOC);
    step("fim_erro", 5'h11, PR | PE);
    for (int i = 0; i < 20; i++) step("erro_hold", 5'h11, PR | PE);
    bus.iniciar = 1;
    step("restart_e", 5'h01, ZR | ZC | ZCR | ZTM | ZT);
    bus.iniciar = 0; bus.meioTM = 1; bus.fimTM = 1;
    step("niv_w", 5'h02, RN);
    step("ini_w", 5'h03, ZC | ZTM);
    step("mostra_w", 5'h04, ALM | TOC | CTM);
    step("apaga_w", 5'h05, CTM);
    step("fim_mostra_w", 5'h07, ZC | ZT);
    step("espera_w", 5'h08, 0);
    bus.jogada_feita = 1;
    step("reg_w", 5'h09, RR | ALJ | TOC);
    bus.jogada_feita = 0; bus.jogada_correta = 1; bus.meioCR = 1;
    step("comp_w", 5'h0A, ALJ | TOC);
    step("fim_acerto", 5'h10, PR | GA);
    step("acerto_hold", 5'h10, PR | GA);
    bus.iniciar = 1;
    step("restart_w", 5'h01, ZR | ZC | ZCR | ZTM | ZT);
    bus.iniciar = 0;
    step("niv_16", 5'h02, RN);
    step("ini_16", 5'h03, ZC | ZTM);
    step("mostra_16", 5'h04, ALM | TOC | CTM);
    step("apaga_16", 5'h05, CTM);
    step("fim_mostra_16", 5'h07, ZC | ZT);
    step("espera_16", 5'h08, 0);
    bus.jogada_feita = 1; bus.nivel_jogadas_reg = 1;
    step("reg_16", 5'h09, RR | ALJ | TOC);
    bus.jogada_feita = 0;
    step("comp_16", 5'h0A, ALJ | TOC);
    step("adiciona_16", 5'h0C, CC | ZT);
    step("esp_escr_16", 5'h0D, 0);
    reset = 1;
    step("rst_mid", 5'h00, 0);
    reset = 0; bus.iniciar = 1;
    step("pre_t", 5'h01, ZR | ZC | ZCR | ZTM | ZT);
    bus.iniciar = 0;
    step("niv_t", 5'h02, RN);
    step("ini_t", 5'h03, ZC | ZTM);
    step("mostra_t", 5'h04, ALM | TOC | CTM);
    step("apaga_t", 5'h05, CTM);
    step("fim_mostra_t", 5'h07, ZC | ZT);
    bus.nivel_tempo_reg = 1;
`ifdef TIMEOUT_EN
    step("espera_t", 5'h08, CT);
    bus.fimTempo = 1;
    step("fim_timeout", 5'h12, PR | TO);
    bus.fimTempo = 0;
    step("timeout_hold", 5'h12, PR | TO);
`else
    step("espera_t", 5'h08, 0);
    bus.fimTempo = 1;
    step("no_timeout", 5'h08, 0);
    bus.fimTempo = 0;
    step("no_timeout_hold", 5'h08, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
